// File: rtl/mul_pkg.sv
// Shared types and constants for the iterative RV32M multiplier.
// Optional feature macro used by mul_unit: MUL_ZERO_EARLY_OUT_EN.
package mul_pkg;

    localparam int XLEN_DEFAULT = 32;

    typedef enum logic [1:0] {
        OP_MUL    = 2'd0,
        OP_MULH   = 2'd1,
        OP_MULHSU = 2'd2,
        OP_MULHU  = 2'd3
    } mul_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } mul_state_e;

    // Number of BUSY cycles needed to retire the whole multiplier.
    function automatic int mul_iter(input int xlen, input int bits_per_cycle);
        return xlen / bits_per_cycle;
    endfunction

endpackage

// File: rtl/mul_step.sv
// One radix-2^BITS_PER_CYCLE step: acc + (mcand * digit) << (cnt * BITS_PER_CYCLE).
// Purely combinational; the caller owns all state.
module mul_step
    import mul_pkg::*;
#(
    parameter int XLEN           = XLEN_DEFAULT,
    parameter int BITS_PER_CYCLE = 4,
    parameter int CNT_W          = 3
) (
    input  logic [2*XLEN-1:0]         acc,
    input  logic [XLEN-1:0]           mcand,
    input  logic [BITS_PER_CYCLE-1:0] digit,
    input  logic [CNT_W-1:0]          cnt,
    output logic [2*XLEN-1:0]         sum
);

    localparam int PW = XLEN + BITS_PER_CYCLE;
    localparam int SW = $clog2(2 * XLEN) + 1;

    logic [PW-1:0]     partial;
    logic [SW-1:0]     shamt;
    logic [2*XLEN-1:0] aligned;

    always_comb begin
        partial = PW'(mcand) * PW'(digit);
        shamt   = SW'(cnt) * SW'(BITS_PER_CYCLE);
        aligned = (2 * XLEN)'(partial) << shamt;
        sum     = acc + aligned;
    end

endmodule

// File: rtl/mul_unit.sv
// Iterative RV32M multiplier (MUL/MULH/MULHSU/MULHU) behind valid/ready handshakes.
// Optional: define MUL_ZERO_EARLY_OUT_EN to skip BUSY when either operand is zero.
module mul_unit
    import mul_pkg::*;
#(
    parameter int XLEN           = XLEN_DEFAULT,
    parameter int BITS_PER_CYCLE = 4
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [1:0]      op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic            kill_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [XLEN-1:0] result_o,
    output logic [1:0]      state_o
);

    localparam int ITER  = mul_iter(XLEN, BITS_PER_CYCLE);
    localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;

    localparam logic [1:0] IDLE = ST_IDLE;
    localparam logic [1:0] BUSY = ST_BUSY;
    localparam logic [1:0] DONE = ST_DONE;

    // Handshakes: a request transfers on a rising edge where valid_i && ready_o && !kill_i;
    // a result transfers on a rising edge where valid_o && ready_i && !kill_i. kill_i wins over both.

    logic [1:0]        state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [2*XLEN-1:0] acc_q;
    logic [XLEN-1:0]   mcand_q;
    logic [XLEN-1:0]   mplier_q;
    logic              negate_q;
    mul_op_e           op_q;

    mul_op_e           op_in;
    logic              a_neg;
    logic              b_neg;
    logic [XLEN-1:0]   a_mag;
    logic [XLEN-1:0]   b_mag;
    logic [2*XLEN-1:0] acc_next;
    logic [2*XLEN-1:0] product;
    logic              last_step;

    // Signed operands enter the datapath as magnitudes; the sign is restored at the end.
    always_comb begin
        op_in = mul_op_e'(op_i);
        a_neg = ((op_in == OP_MULH) || (op_in == OP_MULHSU)) && a_i[XLEN-1];
        b_neg = (op_in == OP_MULH) && b_i[XLEN-1];
        a_mag = a_neg ? ('0 - a_i) : a_i;
        b_mag = b_neg ? ('0 - b_i) : b_i;
    end

    mul_step #(
        .XLEN          (XLEN),
        .BITS_PER_CYCLE(BITS_PER_CYCLE),
        .CNT_W         (CNT_W)
    ) u_step (
        .acc  (acc_q),
        .mcand(mcand_q),
        .digit(mplier_q[BITS_PER_CYCLE-1:0]),
        .cnt  (cnt_q),
        .sum  (acc_next)
    );

    always_comb begin
        last_step = (cnt_q == CNT_W'(ITER - 1));
        product   = negate_q ? ('0 - acc_next) : acc_next;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            negate_q <= 1'b0;
            op_q     <= OP_MUL;
            result_o <= '0;
            valid_o  <= 1'b0;
        end else if (kill_i) begin
            state_q <= IDLE;
            valid_o <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (valid_i) begin
                        op_q     <= op_in;
                        mcand_q  <= a_mag;
                        mplier_q <= b_mag;
                        negate_q <= a_neg ^ b_neg;
                        acc_q    <= '0;
                        cnt_q    <= '0;
`ifdef MUL_ZERO_EARLY_OUT_EN
                        if ((a_i == '0) || (b_i == '0)) begin
                            state_q  <= DONE;
                            result_o <= '0;
                            valid_o  <= 1'b1;
                        end else begin
                            state_q <= BUSY;
                        end
`else
                        state_q <= BUSY;
`endif
                    end
                end
                BUSY: begin
                    acc_q    <= acc_next;
                    mplier_q <= mplier_q >> BITS_PER_CYCLE;
                    cnt_q    <= cnt_q + CNT_W'(1);
                    if (last_step) begin
                        state_q  <= DONE;
                        valid_o  <= 1'b1;
                        result_o <= (op_q == OP_MUL) ? product[XLEN-1:0]
                                                     : product[2*XLEN-1:XLEN];
                    end
                end
                DONE: begin
                    if (ready_i) begin
                        state_q <= IDLE;
                        valid_o <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    valid_o <= 1'b0;
                end
            endcase
        end
    end

    assign ready_o = (state_q == IDLE);
    assign state_o = state_q;

endmodule

// File: tb/tb_mul_unit.sv
// Self-checking bench for mul_unit: directed RV32M corner cases, handshake/kill/reset behaviour
// and randomized operations scored against a 66-bit signed-arithmetic reference model.
module tb_mul_unit;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst_ni = 1'b0;
    logic            valid_i = 1'b0;
    logic            ready_o;
    logic [1:0]      op_i = 2'd0;
    logic [XLEN-1:0] a_i = '0;
    logic [XLEN-1:0] b_i = '0;
    logic            kill_i = 1'b0;
    logic            valid_o;
    logic            ready_i = 1'b0;
    logic [XLEN-1:0] result_o;
    logic [1:0]      state_o;

    int n_tests = 0;
    int n_fail  = 0;
    logic [XLEN-1:0] exp_q[$];

    always #5 clk = ~clk;

    mul_unit #(.XLEN(XLEN), .BITS_PER_CYCLE(4)) dut (
        .clk_i   (clk),
        .rst_ni  (rst_ni),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .op_i    (op_i),
        .a_i     (a_i),
        .b_i     (b_i),
        .kill_i  (kill_i),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .result_o(result_o),
        .state_o (state_o)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: full-width product of the operands as the ISA defines them.
    function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic signed [65:0] sa;
        logic signed [65:0] sb;
        logic signed [65:0] p;
        sa = $signed({((op == 2'd1) || (op == 2'd2)) & a[31], a});
        sb = $signed({(op == 2'd1) & b[31], b});
        p  = sa * sb;
        return (op == 2'd0) ? p[31:0] : p[63:32];
    endfunction

    function automatic int exp_lat(input logic [31:0] a, input logic [31:0] b);
`ifdef MUL_ZERO_EARLY_OUT_EN
        return ((a == 0) || (b == 0)) ? 1 : 9;
`else
        return 9;
`endif
    endfunction

    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int hold, input string tag);
        int lat;
        logic [31:0] held;
        @(negedge clk);
        check({tag, "_rdy"}, ready_o, 1'b1);
        valid_i = 1'b1;
        op_i = op;
        a_i = a;
        b_i = b;
        exp_q.push_back(exp);
        @(negedge clk);
        valid_i = 1'b0;
        a_i = $urandom;
        b_i = $urandom;
        lat = 1;
        while (!valid_o && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_lat"}, lat, exp_lat(a, b));
        if (!valid_o) begin
            void'(exp_q.pop_front());
            return;
        end
        held = result_o;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, "_hold_v"}, valid_o, 1'b1);
            check({tag, "_hold_r"}, result_o, held);
            check({tag, "_hold_rdy"}, ready_o, 1'b0);
        end
        check({tag, "_res"}, result_o, exp_q.pop_front());
        ready_i = 1'b1;
        @(negedge clk);
        ready_i = 1'b0;
        check({tag, "_idle_rdy"}, ready_o, 1'b1);
        check({tag, "_idle_v"}, valid_o, 1'b0);
    endtask

    task automatic accept_only(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        valid_i = 1'b1;
        op_i = op;
        a_i = a;
        b_i = b;
        @(negedge clk);
        valid_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] corner[5];
        logic [31:0] ra;
        logic [31:0] rb;
        logic [1:0]  rop;
        int vcnt;
        int pulses;
        int issued;
        int last;
        corner[0] = 32'h0;
        corner[1] = 32'h1;
        corner[2] = 32'h8000_0000;
        corner[3] = 32'hFFFF_FFFF;
        corner[4] = 32'h7FFF_FFFF;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_valid", valid_o, 1'b0);
        check("rst_ready", ready_o, 1'b1);
        check("rst_result", result_o, 32'h0);
        check("rst_state", state_o, 2'd0);
        rst_ni = 1'b1;

        // Directed vectors
        run_op(2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0, "mulhu_ff");
        run_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 0, "mul_ff");
        run_op(2'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 0, "mulh_min");
        run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 0, "mulh_ff");
        run_op(2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "mulhsu_ff");
        run_op(2'd0, 32'h0000_0000, 32'h1234_5678, 32'h0000_0000, 0, "mul_zero");
        run_op(2'd0, 32'h0000_1234, 32'h0000_5678, 32'h0626_0060, 5, "mul_bp");

        // Reset mid-BUSY: outputs return to reset values without waiting for a clock edge
        accept_only(2'd3, 32'hDEAD_BEEF, 32'h1234_5678);
        repeat (3) @(negedge clk);
        check("rstmid_busy", state_o, 2'd1);
        rst_ni = 1'b0;
        #1;
        check("rstmid_valid", valid_o, 1'b0);
        check("rstmid_ready", ready_o, 1'b1);
        check("rstmid_result", result_o, 32'h0);
        check("rstmid_state", state_o, 2'd0);
        @(negedge clk);
        rst_ni = 1'b1;

        // Kill in BUSY cycle 3
        accept_only(2'd1, 32'h1357_9BDF, 32'h8642_0ECA);
        @(negedge clk);
        @(negedge clk);
        check("kill_busy_state", state_o, 2'd1);
        kill_i = 1'b1;
        @(negedge clk);
        kill_i = 1'b0;
        check("kill_idle_rdy", ready_o, 1'b1);
        check("kill_idle_v", valid_o, 1'b0);
        vcnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (valid_o) vcnt++;
        end
        check("kill_no_valid", vcnt, 0);

        // Kill in IDLE overrides valid_i
        @(negedge clk);
        valid_i = 1'b1;
        kill_i = 1'b1;
        op_i = 2'd0;
        a_i = 32'h5;
        b_i = 32'h7;
        @(negedge clk);
        valid_i = 1'b0;
        kill_i = 1'b0;
        check("kill_idle_state", state_o, 2'd0);

        // Kill in DONE overrides ready_i and drops the result
        accept_only(2'd0, 32'h0000_0003, 32'h0000_0005);
        vcnt = 1;
        while (!valid_o && vcnt < 40) begin
            @(negedge clk);
            vcnt++;
        end
        check("kill_done_reach", valid_o, 1'b1);
        kill_i = 1'b1;
        ready_i = 1'b1;
        @(negedge clk);
        kill_i = 1'b0;
        ready_i = 1'b0;
        check("kill_done_v", valid_o, 1'b0);
        check("kill_done_rdy", ready_o, 1'b1);

        // Randomized operations against the reference model
        for (int n = 0; n < 40; n++) begin
            rop = 2'($urandom_range(0, 3));
            ra = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
            rb = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
            run_op(rop, ra, rb, ref_mul(rop, ra, rb), $urandom_range(0, 2), "rand");
        end

        // Back-to-back throughput with ready_i tied high: one result every ITER+2 cycles
        ready_i = 1'b1;
        pulses = 0;
        issued = 0;
        last = -1;
        for (int cyc = 0; cyc < 60 && pulses < 3; cyc++) begin
            if (valid_o) begin
                if (exp_q.size() == 0) check("tp_unexpected", 1'b1, 1'b0);
                else check("tp_res", result_o, exp_q.pop_front());
                if (last >= 0) check("tp_gap", cyc - last, 10);
                last = cyc;
                pulses++;
            end
            if (ready_o && issued < 3) begin
                rop = 2'($urandom_range(0, 3));
                ra = $urandom | 32'h1;
                rb = $urandom | 32'h1;
                op_i = rop;
                a_i = ra;
                b_i = rb;
                valid_i = 1'b1;
                exp_q.push_back(ref_mul(rop, ra, rb));
                issued++;
            end else begin
                valid_i = 1'b0;
            end
            @(negedge clk);
        end
        valid_i = 1'b0;
        ready_i = 1'b0;
        check("tp_pulses", pulses, 3);
        check("tp_drained", exp_q.size(), 0);
        check("tp_idle", ready_o, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mul_unit.md
# mul_unit

Parametrised, iterative integer multiplier implementing the RV32M MUL, MULH, MULHSU and MULHU operations. It is the sequential successor to the single-cycle combinational multiplier and sits in the execute stage as a multi-cycle functional unit behind a valid/ready handshake. Each cycle it consumes `BITS_PER_CYCLE` bits of the multiplier, trading latency for area and timing.

## Interface
- `XLEN`, default 32: operand and result width.
- `BITS_PER_CYCLE`, default 4: multiplier bits retired per BUSY cycle. Must divide `XLEN`. `ITER = XLEN/BITS_PER_CYCLE`.
- `clk_i`  in  1: clock; single clock domain.
- `rst_ni`  in  1: asynchronous, active-low reset.
- `valid_i`  in  1: request valid.
- `ready_o`  out  1: unit can accept a request; high only in IDLE.
- `op_i`  in  2: 0=MUL, 1=MULH, 2=MULHSU, 3=MULHU.
- `a_i`  in  XLEN: rs1 operand.
- `b_i`  in  XLEN: rs2 operand.
- `kill_i`  in  1: synchronous abort of any in-flight operation.
- `valid_o`  out  1: result valid.
- `ready_i`  in  1: consumer accepts the result.
- `result_o`  out  XLEN: selected half of the product.

## Operation
- FSM states are IDLE, BUSY and DONE. Reset enters IDLE.
- **IDLE:** `ready_o=1`. When `valid_i` is high and `kill_i` is low, the unit latches the operation, operand magnitudes, the negate flag, a cleared 2·XLEN accumulator and cnt=0, then moves to BUSY.
- **Signedness:**
  - MULH treats both operands as signed.
  - MULHSU treats a as signed and b as unsigned.
  - MULHU and MUL treat both operands as unsigned. MUL's low half is identical for signed and unsigned operands.
  - Signed negative operands are replaced by their two's-complement magnitude. negate = sign(a_eff) XOR sign(b_eff).
- **BUSY:** each cycle, acc += |a| · (next `BITS_PER_CYCLE` bits of |b|, LSB first) shifted into place, and cnt increments. When cnt reaches ITER−1, the sign fix is applied (product = negate ? −acc : acc, modulo 2^(2·XLEN)). `result_o` is loaded with the low XLEN bits for MUL, or the high XLEN bits otherwise. The state then moves to DONE.
- **DONE:** `valid_o=1`. `result_o` is held stable until `ready_i`, then the state returns to IDLE. `ready_o` is low in DONE, so there is no accept in the same cycle.
- **kill_i:** high in any state, it forces IDLE at the next edge with `valid_o=0`. It overrides `valid_i` in IDLE and `ready_i` in DONE. A killed result is never presented.
- **Reset mid-operation:** immediate return to IDLE. The accumulator contents are discarded.
- **Arithmetic:** all internal arithmetic is unsigned at 2·XLEN bits. The digit product is XLEN+`BITS_PER_CYCLE` bits wide. There is no overflow flag. The most-negative operand (0x80000000) has magnitude 2^31, which fits unsigned.

## Timing
- Reset values: `valid_o=0`, `ready_o=1`, `result_o=0`, state=IDLE.
- **Latency:** accept in cycle 0, `valid_o` high in cycle ITER+1. The default configuration gives 9 cycles.
- **Throughput:** one operation per ITER+2 cycles with `ready_i` tied high.
- `ready_o` is decoded from the state register only, with no combinational path from inputs.
- `result_o` and `valid_o` are registered.

## Configuration
- `MUL_ZERO_EARLY_OUT_EN`
  - **Defined:** if either operand is zero at accept, the unit goes directly IDLE→DONE with `result_o=0`, and `valid_o` rises in cycle 1.
  - **Undefined:** every operation takes the full ITER+1 cycles, and there is no zero-detect logic.

## Structure
- **Package `mul_pkg`:**
  - the `mul_op_e` enum (MUL, MULH, MULHSU, MULHU);
  - the `mul_state_e` enum (IDLE, BUSY, DONE);
  - `XLEN` default constant;
  - `mul_iter()` function returning XLEN/BITS_PER_CYCLE.
- **Sub-module `mul_step`:** combinational, computes acc + (mcand · digit) << (cnt·`BITS_PER_CYCLE`).
- **`mul_unit`:** owns the FSM, counter, sign preprocessing and postprocessing, and the handshake.

## Test plan
- MULHU a=0xFFFFFFFF, b=0xFFFFFFFF -> `result_o`=0xFFFFFFFE. MUL with the same operands -> 0x00000001. `valid_o` rises exactly in cycle 9.
- MULH a=0x80000000, b=0x80000000 -> 0x40000000. MULH a=0xFFFFFFFF, b=0xFFFFFFFF -> 0x00000000.
- MULHSU a=0xFFFFFFFF, b=0xFFFFFFFF -> 0xFFFFFFFF. MUL a=0x00001234, b=0x00005678 -> 0x06260060.
- Backpressure: hold `ready_i` low 5 cycles in DONE -> `valid_o` stays high, `result_o` is stable, `ready_o` is low. Raise `ready_i` -> IDLE next cycle and `ready_o=1`.
- `kill_i` in BUSY cycle 3 -> IDLE next edge, and no `valid_o` pulse. Assert `rst_ni` low mid-BUSY -> all outputs return to their reset values immediately.
- With `MUL_ZERO_EARLY_OUT_EN`: MUL a=0, b=0x12345678 -> `result_o`=0 with `valid_o` in cycle 1. Without the macro -> `result_o`=0 in cycle 9.
